seq_bit_serializer: RTL and testbench
=====================================

// Module: seq_bit_serializer
// PURPOSE
//   Parallel-to-serial source stage directly upstream of SEQ_BLK. Accepts WIDTH-bit
//   words over a valid/ready handshake and drives them one bit per clock onto ser_out,
//   which connects to SEQ_BLK.in. A one-word holding register lets the next word
//   arrive while the current one shifts. GAP idle cycles (ser_out=0) separate frames.
// PARAMETERS
//   WIDTH      8   bits per word; legal range 2..32
//   GAP        2   cycles of ser_out=0 after each word; 0 = back-to-back frames; legal 0..15
//   MSB_FIRST  1   1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
// PORTS
//   clk         in   1      single clock; all state updates on the rising edge
//   rst         in   1      synchronous, active-high reset
//   data_in     in   WIDTH  word to serialize
//   data_valid  in   1      data_in is valid this cycle
//   data_ready  out  1      holding register can accept a word
//   ser_out     out  1      serial bit to SEQ_BLK.in
//   ser_active  out  1      high while ser_out carries a data bit (state SHIFT)
//   ser_last    out  1      high during the last bit of a word
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, hold_full=0, shift reg=0, bit_cnt=0, gap_cnt=0.
//     Outputs after that edge: data_ready=1, ser_out=0, ser_active=0, ser_last=0.
//     Reset wins over every other event. A word in flight or in the hold register is discarded.
//   Handshake: data_ready = !hold_full (no combinational path from data_valid).
//     Accept = data_valid & data_ready at an edge: hold <= data_in, hold_full <= 1.
//     data_in and data_valid are don't-care when data_ready=0.
//   Load: shifter <= hold, hold_full <= 0, bit_cnt <= 0, state <= SHIFT. This happens at the
//     same edge as the condition below. The hold register cannot accept a word at the load
//     edge because data_ready is still 0.
//   FSM (all outputs registered or decoded from state):
//     IDLE : ser_out=0. Condition hold_full=1 -> Load.
//     SHIFT: ser_out = current bit (MSB or LSB per MSB_FIRST). Each edge shifts the register
//            and increments bit_cnt. ser_last = (bit_cnt==WIDTH-1).
//            At the edge that ends the last bit:
//              GAP>0               -> state GAP, gap_cnt=0
//              GAP==0 & hold_full  -> Load (next word follows with no idle cycle)
//              GAP==0 & !hold_full -> IDLE
//     GAP  : ser_out=0. gap_cnt increments each edge. At the edge ending gap cycle GAP:
//              hold_full -> Load; else -> IDLE.
//   Latency: word accepted at edge t while IDLE and empty -> Load at edge t+1. Its first bit
//     appears on ser_out in the cycle after edge t+1. The word occupies exactly WIDTH
//     consecutive cycles.
//   Throughput: one word per WIDTH+GAP cycles when upstream keeps the hold register full.
//   Boundaries:
//     - Hold full during SHIFT/GAP: data_ready=0; upstream stalls.
//     - data_valid held high continuously: no word is dropped or duplicated.
//     - Counters never exceed WIDTH-1 / GAP-1 and wrap to 0 on Load.
// TESTING
//   1 Reset then idle: rst high 2 cycles, valid=0 for 20 cycles
//     -> ser_out=0, ser_active=0, data_ready=1 throughout.
//   2 Single word, WIDTH=8, MSB_FIRST=1: send 8'hA5 at edge t
//     -> ser_out = 1,0,1,0,0,1,0,1 in cycles t+2..t+9; ser_last only in cycle t+9;
//        then 2 zero cycles; then IDLE.
//   3 Back-to-back, GAP=0: send 8'hF0 and 8'h0F with valid held high
//     -> 16 contiguous bits 1111000000001111; ser_active high for all 16 cycles;
//        data_ready low while the second word waits in the hold register.
//   4 LSB-first, GAP=2: send 8'h01 then 8'h80
//     -> 1,0,0,0,0,0,0,0, 0,0 (gap), 0,0,0,0,0,0,0,1.
//   5 Reset mid-word: assert rst after the 3rd bit of 8'hFF with a second word in hold
//     -> ser_out=0 and data_ready=1 after that edge; neither word's remaining bits ever appear.
//   6 End-to-end with SEQ_BLK: drive its pattern stimulus (0,1,0,1) through the serializer
//     -> SEQ_BLK outA/outB/outC match the direct-stimulus run, shifted by the serializer latency.

Source files
------------

// File: rtl/seq_bit_serializer_if.sv
// Word handshake between an upstream producer and seq_bit_serializer.
//   data_in    : word to serialize (WIDTH bits)
//   data_valid : data_in is valid this cycle
//   data_ready : serializer holding register can accept a word
interface seq_bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial source stage feeding SEQ_BLK.in. Accepts WIDTH-bit words over a
// valid/ready handshake into a one-word holding register and shifts them out one bit
// per clock, separated by GAP idle cycles.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   bus        : word handshake (slave side): data_in, data_valid, data_ready
//   ser_out    : serial bit
//   ser_active : ser_out carries a data bit
//   ser_last   : last bit of the current word
module seq_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned GAP       = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_bit_serializer_if.slave   bus,
    output logic                  ser_out,
    output logic                  ser_active,
    output logic                  ser_last
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = 4;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    // GAP==0 never enters S_GAP, so its terminal value is irrelevant there.
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP == 0) ? '0 : GAP_W'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] shifter;
    logic             hold_full;
    logic [CNT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic             load_c;
    logic             accept_c;
    logic             bit_end_c;
    logic             gap_end_c;

    assign accept_c  = bus.data_valid && !hold_full;
    assign bit_end_c = (state == S_SHIFT) && (bit_cnt == BIT_LAST);
    assign gap_end_c = (state == S_GAP) && (gap_cnt == GAP_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and load decision
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    load_c    = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_end_c) begin
                    if (GAP != 0) begin
                        state_nxt = S_GAP;
                    end else if (hold_full) begin
                        load_c    = 1'b1;
                        state_nxt = S_SHIFT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_end_c) begin
                    if (hold_full) begin
                        load_c    = 1'b1;
                        state_nxt = S_SHIFT;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Holding register, shifter and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
            shifter   <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            // A load only happens with hold_full set, so it never coincides with an accept.
            if (load_c) begin
                shifter   <= hold;
                hold_full <= 1'b0;
            end else begin
                if (accept_c) begin
                    hold      <= bus.data_in;
                    hold_full <= 1'b1;
                end
                if (state == S_SHIFT) begin
                    shifter <= MSB_FIRST ? {shifter[WIDTH-2:0], 1'b0}
                                         : {1'b0, shifter[WIDTH-1:1]};
                end
            end

            if (load_c || bit_end_c) begin
                bit_cnt <= '0;
            end else if (state == S_SHIFT) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if ((state == S_GAP) && !gap_end_c) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.data_ready = !hold_full;
        ser_out        = 1'b0;
        ser_active     = 1'b0;
        ser_last       = 1'b0;
        if (state == S_SHIFT) begin
            ser_out    = MSB_FIRST ? shifter[WIDTH-1] : shifter[0];
            ser_active = 1'b1;
            ser_last   = (bit_cnt == BIT_LAST);
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: three instances cover MSB-first with GAP=2,
// MSB-first back-to-back (GAP=0) and LSB-first with GAP=2.
module tb_seq_bit_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    seq_bit_serializer_if #(.WIDTH(8)) bus_a ();
    seq_bit_serializer_if #(.WIDTH(8)) bus_b ();
    seq_bit_serializer_if #(.WIDTH(8)) bus_c ();

    logic out_a, act_a, last_a;
    logic out_b, act_b, last_b;
    logic out_c, act_c, last_c;

    seq_bit_serializer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .ser_out(out_a), .ser_active(act_a), .ser_last(last_a)
    );
    seq_bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .ser_out(out_b), .ser_active(act_b), .ser_last(last_b)
    );
    seq_bit_serializer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b0)) u_c (
        .clk(clk), .rst(rst), .bus(bus_c),
        .ser_out(out_c), .ser_active(act_c), .ser_last(last_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [15:0] pat_b;
    logic [17:0] pat_c;
    logic [7:0]  w;

    initial begin
        bus_a.data_in = '0; bus_a.data_valid = 1'b0;
        bus_b.data_in = '0; bus_b.data_valid = 1'b0;
        bus_c.data_in = '0; bus_c.data_valid = 1'b0;

        // 1: reset two cycles, then idle
        rst = 1'b1;
        step();
        step();
        chk("rst_ready_a", bus_a.data_ready, 1'b1);
        chk("rst_out_a", out_a, 1'b0);
        chk("rst_ready_b", bus_b.data_ready, 1'b1);
        chk("rst_ready_c", bus_c.data_ready, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_out", out_a, 1'b0);
            chk("idle_act", act_a, 1'b0);
            chk("idle_ready", bus_a.data_ready, 1'b1);
        end

        // 2: single word 8'hA5, MSB first, GAP=2
        w = 8'hA5;
        bus_a.data_in = w; bus_a.data_valid = 1'b1;
        step();                                   // edge t: accept
        bus_a.data_valid = 1'b0;
        chk("t2_ready_full", bus_a.data_ready, 1'b0);
        chk("t2_out_latency", out_a, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t2_bit", out_a, w[7-i]);
            chk("t2_act", act_a, 1'b1);
            chk("t2_last", last_a, (i == 7));
        end
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t2_gap_out", out_a, 1'b0);
            chk("t2_gap_act", act_a, 1'b0);
        end
        step();
        chk("t2_idle_out", out_a, 1'b0);
        chk("t2_idle_act", act_a, 1'b0);
        chk("t2_idle_ready", bus_a.data_ready, 1'b1);

        // 3: back-to-back F0 then 0F with GAP=0, valid held high
        pat_b = 16'b1111000000001111;
        bus_b.data_in = 8'hF0; bus_b.data_valid = 1'b1;
        step();                                   // accept F0
        bus_b.data_in = 8'h0F;
        chk("t3_ready_first", bus_b.data_ready, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t3_bit", out_b, pat_b[15-i]);
            chk("t3_act", act_b, 1'b1);
            chk("t3_last", last_b, (i == 7) || (i == 15));
            chk("t3_ready", bus_b.data_ready, (i == 0) || (i >= 8));
            if (i == 1) bus_b.data_valid = 1'b0;  // 0F accepted at this edge
        end
        step();
        chk("t3_end_out", out_b, 1'b0);
        chk("t3_end_act", act_b, 1'b0);

        // 4: LSB first, GAP=2: 8'h01 then 8'h80
        pat_c = 18'b1_0000000_00_0000000_1;      // bit 17 is emitted first
        bus_c.data_in = 8'h01; bus_c.data_valid = 1'b1;
        step();                                   // accept 01
        bus_c.data_in = 8'h80;
        for (int i = 0; i < 18; i++) begin
            step();
            chk("t4_bit", out_c, pat_c[17-i]);
            chk("t4_act", act_c, (i < 8) || (i >= 10));
            chk("t4_ready", bus_c.data_ready, (i == 0) || (i >= 10));
            if (i == 1) bus_c.data_valid = 1'b0;  // 80 accepted at this edge
        end
        step();
        chk("t4_end_act", act_c, 1'b0);

        // 5: reset after the 3rd bit of 8'hFF with 8'hAA waiting in hold
        bus_a.data_in = 8'hFF; bus_a.data_valid = 1'b1;
        step();                                   // accept FF
        bus_a.data_in = 8'hAA;
        step();                                   // load FF, bit 1
        chk("t5_bit1", out_a, 1'b1);
        step();                                   // bit 2, AA accepted
        bus_a.data_valid = 1'b0;
        chk("t5_bit2", out_a, 1'b1);
        chk("t5_hold_full", bus_a.data_ready, 1'b0);
        step();                                   // bit 3
        chk("t5_bit3", out_a, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_out", out_a, 1'b0);
        chk("t5_rst_act", act_a, 1'b0);
        chk("t5_rst_ready", bus_a.data_ready, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_after_out", out_a, 1'b0);
            chk("t5_after_act", act_a, 1'b0);
            chk("t5_after_ready", bus_a.data_ready, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
